seg7_scan_driver: RTL



---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_driver.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are active-low, bit order {A,B,C,D,E,F,G,P} with A as the MSB.
package seg7_pkg;

  typedef logic [7:0] seg_t;

  // All segments and the decimal point dark.
  localparam seg_t SEG_OFF = 8'hFF;

  // Hex digit to active-low segments; P is left dark (1) in every entry.
  localparam seg_t SEG_TABLE [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble_i  4-bit hex digit
//   seg_o     active-low segments {A..G,P}; P is always 1 (dark)
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Inputs are sampled into shadow registers once per frame (on the last cycle of the last
// digit slot) so a frame never mixes old and new digits. Each slot starts with a blanking
// window to suppress ghosting; anode and catode are registered (1-cycle latency).
//
// Optional feature: define SEG7_LZ_SUPPRESS_EN to blank leading zero digits. The mask is
// computed from the input value at latch time and stored with the shadows. Digit 0 is never
// suppressed, and a suppressed digit still shows its decimal point.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   value       packed hex digits, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_mask     1 = light decimal point of digit i
//   digit_en    1 = digit i shown, 0 = digit fully dark (including DP)
//   anode       active-low digit select, at most one bit low
//   catode      active-low segments {A,B,C,D,E,F,G,P}
//   frame_done  one-cycle pulse in the cycle whose closing edge latches the inputs
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              catode,
  output logic                    frame_done
);

  localparam int unsigned TickW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TickW-1:0] TickLast  = TickW'(REFRESH_DIV - 1);
  localparam logic [TickW-1:0] TickBlank = TickW'(BLANK_CYCLES);
  localparam logic [IdxW-1:0]  IdxLast   = IdxW'(NUM_DIGITS - 1);

  // Scan counters
  logic [TickW-1:0] tick_d, tick_q;
  logic [IdxW-1:0]  idx_d, idx_q;
  logic             tick_wrap;
  logic             frame_end;

  // Shadow copies of the display inputs
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   en_q;

  // Registered outputs
  logic [NUM_DIGITS-1:0] anode_d, anode_q;
  seg_t                  catode_d, catode_q;

  // Current-digit selections from the shadows
  logic [3:0] nib_sel;
  logic       dp_sel;
  logic       en_sel;
  logic       hide_sel;
  logic       blank;
  seg_t       dec_seg;

  always_comb begin
    tick_wrap = (tick_q == TickLast);
    frame_end = tick_wrap && (idx_q == IdxLast);
    tick_d    = tick_wrap ? '0 : tick_q + TickW'(1);
    idx_d     = idx_q;
    if (tick_wrap) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      idx_q  <= '0;
    end else begin
      tick_q <= tick_d;
      idx_q  <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      dp_q    <= '0;
      en_q    <= '0;
    end else if (frame_end) begin
      value_q <= value;
      dp_q    <= dp_mask;
      en_q    <= digit_en;
    end
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] lz_d, lz_q;
  logic                  zero_run;

  // Walk from the top digit down; a digit is suppressed while it and everything above is 0.
  always_comb begin
    lz_d     = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (value[4*i +: 4] == 4'h0);
      lz_d[i]  = zero_run;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lz_q <= '0;
    end else if (frame_end) begin
      lz_q <= lz_d;
    end
  end

  always_comb begin
    hide_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        hide_sel = lz_q[i];
      end
    end
  end
`else
  assign hide_sel = 1'b0;
`endif

  // Loop mux keeps indexing in range for non-power-of-two digit counts.
  always_comb begin
    nib_sel = 4'h0;
    dp_sel  = 1'b0;
    en_sel  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        nib_sel = value_q[4*i +: 4];
        dp_sel  = dp_q[i];
        en_sel  = en_q[i];
      end
    end
  end

  seg7_hex_decode u_hex_decode (
    .nibble_i (nib_sel),
    .seg_o    (dec_seg)
  );

  always_comb begin
    blank    = (tick_q < TickBlank);
    anode_d  = '1;
    catode_d = SEG_OFF;
    if (!blank) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == IdxW'(i)) begin
          anode_d[i] = 1'b0;
        end
      end
      // A disabled digit keeps its anode slot so overall brightness stays constant.
      if (en_sel) begin
        catode_d = {(hide_sel ? 7'h7F : dec_seg[7:1]), ~dp_sel};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_q  <= '1;
      catode_q <= SEG_OFF;
    end else begin
      anode_q  <= anode_d;
      catode_q <= catode_d;
    end
  end

  assign anode      = anode_q;
  assign catode     = catode_q;
  assign frame_done = frame_end;

endmodule
